// File: rtl/display_pkg.sv
// Shared types and default 640x480@60 raster constants for the display scanout path.
package display_pkg;

    localparam int FB_W     = 128;
    localparam int FB_H     = 64;
    localparam int FB_AW    = 13;
    localparam int FB_COL_W = 7;
    localparam int FB_ROW_W = 6;
    localparam int CNT_W    = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Per-pixel flags carried down the pipeline alongside the memory read.
    typedef struct packed {
        logic win;
        logic act;
        logic hsync;
        logic vsync;
        logic first;
    } flags_t;

endpackage

// File: rtl/display_scanout_if.sv
// Framebuffer read port plus video output bundle of the scanout block.
interface display_scanout_if;
    import display_pkg::*;

    logic             mem_re;
    logic [FB_AW-1:0] mem_raddr;
    pixel_t           mem_rdata;
    logic [7:0]       vga_r;
    logic [7:0]       vga_g;
    logic [7:0]       vga_b;
    logic             vga_hs;
    logic             vga_vs;
    logic             vga_de;
    logic             frame_start;

    modport master (
        output mem_re, mem_raddr,
        input  mem_rdata,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start
    );

    modport slave (
        input  mem_re, mem_raddr,
        output mem_rdata,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start
    );

endinterface

// File: rtl/display_timing.sv
// Raster h/v counters and the raw stage-0 active, window and sync flags.
module display_timing
    import display_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned SCALE    = 4,
    parameter int unsigned X_OFF    = 64,
    parameter int unsigned Y_OFF    = 112
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v,
    output logic             o_active,
    output logic             o_window,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_first
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] X_LO   = CNT_W'(X_OFF);
    localparam logic [CNT_W-1:0] X_HI   = CNT_W'(X_OFF + FB_W * SCALE);
    localparam logic [CNT_W-1:0] Y_LO   = CNT_W'(Y_OFF);
    localparam logic [CNT_W-1:0] Y_HI   = CNT_W'(Y_OFF + FB_H * SCALE);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign o_h      = r_h;
    assign o_v      = r_v;
    assign o_active = (r_h < H_ACT) && (r_v < V_ACT);
    assign o_window = (r_h >= X_LO) && (r_h < X_HI) && (r_v >= Y_LO) && (r_v < Y_HI);
    assign o_hsync  = (r_h >= HS_LO) && (r_h < HS_HI);
    assign o_vsync  = (r_v >= VS_LO) && (r_v < VS_HI);
    assign o_first  = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/display_scanout.sv
// Framebuffer scanout: window address generation and the 3-stage colour/sync alignment pipeline.
module display_scanout
    import display_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned SCALE    = 4,
    parameter int unsigned X_OFF    = 64,
    parameter int unsigned Y_OFF    = 112,
    parameter pixel_t      BORDER   = 24'h000000
) (
    input  logic              clk,
    input  logic              rst_n,
    display_scanout_if.master dsp
);

    localparam int               SHIFT = $clog2(SCALE);
    localparam logic [CNT_W-1:0] X_LO  = CNT_W'(X_OFF);
    localparam logic [CNT_W-1:0] Y_LO  = CNT_W'(Y_OFF);

    logic [CNT_W-1:0]    w_h;
    logic [CNT_W-1:0]    w_v;
    logic                w_active;
    logic                w_window;
    logic                w_hsync;
    logic                w_vsync;
    logic                w_first;
    logic [FB_COL_W-1:0] w_col;
    logic [FB_ROW_W-1:0] w_row;
    pixel_t              w_rgb_next;

    logic             r_mem_re;
    logic [FB_AW-1:0] r_mem_raddr;
    flags_t           r_s1;
    flags_t           r_s2;
    pixel_t           r_rgb;
    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic             r_fs;

    display_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SCALE    (SCALE),
        .X_OFF    (X_OFF),
        .Y_OFF    (Y_OFF)
    ) u_timing (
        .clk      (clk),
        .rst_n    (rst_n),
        .o_h      (w_h),
        .o_v      (w_v),
        .o_active (w_active),
        .o_window (w_window),
        .o_hsync  (w_hsync),
        .o_vsync  (w_vsync),
        .o_first  (w_first)
    );

    // Window-relative offset in counter width, then scaled down and truncated to memory coordinates.
    assign w_col = FB_COL_W'((w_h - X_LO) >> SHIFT);
    assign w_row = FB_ROW_W'((w_v - Y_LO) >> SHIFT);

    // NOTE: always_comb assigns a default first so no path can leave the output unassigned (no latch).
    always_comb begin
        w_rgb_next = '0;
        if (r_s2.win) begin
            w_rgb_next = dsp.mem_rdata;
        end else if (r_s2.act) begin
            w_rgb_next = BORDER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_re    <= 1'b0;
            r_mem_raddr <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_rgb       <= '0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_de        <= 1'b0;
            r_fs        <= 1'b0;
        end else begin
            r_mem_re <= w_window;
            if (w_window) begin
                r_mem_raddr <= {w_row, w_col};
            end
            r_s1  <= '{win: w_window, act: w_active, hsync: w_hsync, vsync: w_vsync, first: w_first};
            r_s2  <= r_s1;
            r_rgb <= w_rgb_next;
            r_hs  <= ~r_s2.hsync;
            r_vs  <= ~r_s2.vsync;
            r_de  <= r_s2.act;
            r_fs  <= r_s2.first;
        end
    end

    assign dsp.mem_re      = r_mem_re;
    assign dsp.mem_raddr   = r_mem_raddr;
    assign dsp.vga_r       = r_rgb.r;
    assign dsp.vga_g       = r_rgb.g;
    assign dsp.vga_b       = r_rgb.b;
    assign dsp.vga_hs      = r_hs;
    assign dsp.vga_vs      = r_vs;
    assign dsp.vga_de      = r_de;
    assign dsp.frame_start = r_fs;

endmodule

// File: tb/tb_display_scanout.sv
// Scanout bench on a reduced raster: random framebuffer, position-arithmetic reference model.
module tb_display_scanout;
    import display_pkg::*;

    localparam int HA = 272, HF = 8, HS = 16, HB = 8;
    localparam int VA = 136, VF = 2, VS = 2, VB = 4;
    localparam int SC = 2, XO = 8, YO = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] BRD = 24'h123456;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_scanout_if bus ();

    display_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SCALE    (SC), .X_OFF (XO), .Y_OFF (YO), .BORDER (BRD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dsp   (bus)
    );

    logic [23:0] fb [8192];

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= fb[bus.mem_raddr];
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n;
    logic [12:0] last_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", tag, n, obs, exp);
    endtask

    function automatic logic in_win(int h, int v);
        return (h >= XO) && (h < XO + 128 * SC) && (v >= YO) && (v < YO + 64 * SC);
    endfunction

    function automatic logic [12:0] addr_of(int h, int v);
        logic [5:0] row;
        logic [6:0] col;
        row = 6'((v - YO) / SC);
        col = 7'((h - XO) / SC);
        return {row, col};
    endfunction

    // n = clock edges since reset release; counters sit at raster position n.
    task automatic check_cycle(input string tag);
        int p, h, v;
        logic re_e;
        logic [12:0] addr_e;
        logic [23:0] rgb_e;
        logic hs_e, vs_e, de_e, fs_e;
        re_e = 1'b0;
        addr_e = last_addr;
        if (n >= 1) begin
            p = (n - 1) % FRAME; h = p % HT; v = p / HT;
            if (in_win(h, v)) begin re_e = 1'b1; addr_e = addr_of(h, v); end
        end
        last_addr = addr_e;
        check({tag, "_mem"}, 64'({bus.mem_re, bus.mem_raddr}), 64'({re_e, addr_e}));

        rgb_e = 24'h0; hs_e = 1'b1; vs_e = 1'b1; de_e = 1'b0; fs_e = 1'b0;
        if (n >= 3) begin
            p = (n - 3) % FRAME; h = p % HT; v = p / HT;
            de_e = (h < HA) && (v < VA);
            if (in_win(h, v)) rgb_e = fb[addr_of(h, v)];
            else if (de_e) rgb_e = BRD;
            hs_e = !((h >= HA + HF) && (h < HA + HF + HS));
            vs_e = !((v >= VA + VF) && (v < VA + VF + VS));
            fs_e = (p == 0);
        end
        check({tag, "_vid"},
              64'({bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs, bus.vga_de, bus.frame_start}),
              64'({rgb_e, hs_e, vs_e, de_e, fs_e}));
    endtask

    int hs_fall1, hs_fall2, vs_fall, vs_low, fs_cnt, fs_de_cnt;
    logic prev_hs, prev_vs;

    task automatic run(input int cycles, input logic stats);
        repeat (cycles) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            check_cycle("run");
            if (stats) begin
                if (prev_hs && !bus.vga_hs) begin
                    if (hs_fall1 < 0) hs_fall1 = n;
                    else if (hs_fall2 < 0) hs_fall2 = n;
                end
                if (prev_vs && !bus.vga_vs && vs_fall < 0) vs_fall = n;
                if (!bus.vga_vs) vs_low++;
                if (bus.frame_start) begin
                    fs_cnt++;
                    if (bus.vga_de) fs_de_cnt++;
                end
                prev_hs = bus.vga_hs;
                prev_vs = bus.vga_vs;
            end
        end
    endtask

    initial begin
        int rv, rh;
        for (int i = 0; i < 8192; i++) fb[i] = 24'($urandom);
        n = 0;
        last_addr = '0;
        repeat (4) begin
            @(negedge clk);
            check_cycle("reset");
        end
        rst_n = 1'b1;

        // First run into the window, then reset at a random in-window position.
        rv = $urandom_range(YO + 20, YO);
        rh = $urandom_range(XO + 255, XO);
        run(rv * HT + rh, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n = 0;
        last_addr = '0;
        check_cycle("midrst");
        repeat (3) begin
            @(negedge clk);
            check_cycle("midrst_hold");
        end
        rst_n = 1'b1;

        hs_fall1 = -1; hs_fall2 = -1; vs_fall = -1;
        vs_low = 0; fs_cnt = 0; fs_de_cnt = 0;
        prev_hs = bus.vga_hs; prev_vs = bus.vga_vs;
        run(FRAME + 2 * HT, 1'b1);

        check("hs_first_fall", 64'(hs_fall1), 64'(HA + HF + 3));
        check("hs_period", 64'(hs_fall2 - hs_fall1), 64'(HT));
        check("vs_first_fall", 64'(vs_fall), 64'((VA + VF) * HT + 3));
        check("vs_low_clocks", 64'(vs_low), 64'(VS * HT));
        check("frame_start_cnt", 64'(fs_cnt), 64'(2));
        check("frame_start_de", 64'(fs_de_cnt), 64'(2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scanout.md
# display_scanout

Framebuffer reader for the VGA display path. Walks a 640x480@60 raster on a 25.175 MHz pixel clock and fetches pixels from the 128x64x24-bit display memory. That memory is addressed as {y[5:0], x[6:0]} and filled by the display write port. Each fetched pixel is scaled by SCALE and placed in a centred window, and the block drives registered RGB, sync and data-enable to the DAC/HDMI encoder.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (clocks)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- SCALE, 4, pixel replication factor; power of two only
- X_OFF / Y_OFF, 64 / 112, window origin in active coordinates
- BORDER, 24'h000000, RGB shown in active area outside window
- clk  in  1  pixel clock; only clock
- rst_n  in  1  asynchronous active-low reset
- mem_re  out  1  read strobe, high only for in-window pixels
- mem_raddr  out  13  {row[5:0], col[6:0]}
- mem_rdata  in  24  {r,g,b}; synchronous memory, valid one clock after mem_raddr/mem_re
- vga_r / vga_g / vga_b  out  8 each  pixel colour
- vga_hs / vga_vs  out  1  syncs, active low
- vga_de  out  1  active-video flag
- frame_start  out  1  one-clock pulse with output pixel (0,0)

## Operation
- Counters h in 0..799 and v in 0..524.
  - h wraps 799->0 and increments v.
  - v wraps 524->0 on the same edge that h wraps at (799, 524).
- Active region: h < 640 and v < 480.
- Window: X_OFF <= h < X_OFF+128*SCALE and Y_OFF <= v < Y_OFF+64*SCALE, i.e. 512x256 at defaults.
- col = (h-X_OFF) >> log2(SCALE) and row = (v-Y_OFF) >> log2(SCALE). Subtraction is done in counter width; results are truncated to 7 and 6 bits.
- mem_re=1 exactly when the counters are in the window. mem_raddr holds its last value when mem_re=0.
- Raw hs is low for 656 <= h < 752. Raw vs is low for 490 <= v < 492.
- Output colour:
  - mem_rdata if the pipelined in-window flag is set;
  - else BORDER if the pipelined active flag is set;
  - else 0.
- Every edge-case at a wrap is purely counter-driven; no handshake and no stall. mem_rdata is trusted the cycle after mem_re.
- Reset, including mid-frame: all state clears asynchronously and the raster restarts at (0,0) on the first clock after release.

## Timing
- Stage 0: counters hold (h,v).
- Stage 1: mem_re/mem_raddr registered, plus in-window, active, hs and vs flags.
- Stage 2: memory returns data.
- Stage 3: output registers load.
- Outputs for position (h,v) therefore appear 3 clocks after the counters hold (h,v). hs, vs, de and frame_start are delayed by exactly 3 to stay aligned with colour.
- mem_re/mem_raddr for (h,v) are valid 1 clock after the counters hold (h,v).
- Reset values:
  - h = v = 0, all pipeline flags 0.
  - mem_re = 0, mem_raddr = 0.
  - vga_r/g/b = 0, vga_de = 0, frame_start = 0.
  - vga_hs = vga_vs = 1.
- Line period 800 clocks; frame period 420000 clocks.

## Structure
- Package display_pkg:
  - FB_W=128, FB_H=64, FB_AW=13;
  - typedef pixel_t (24-bit packed {r,g,b});
  - default VGA 640x480 timing constants.
- Sub-module display_timing: h/v counters plus raw active/window/sync flags for stage 0. Shares display_pkg.
- The top level holds the address generation and the 3-stage alignment pipeline.

## Test plan
- Reset, hold rst_n=0, then release: all outputs at reset values while low. After release, first vga_hs falling edge 659 clocks later (656+3); hs low 96 clocks, period 800.
- vsync: vga_vs low for 1600 clocks, starting 490*800+3 clocks after release; frame_start pulses every 420000 clocks with vga_de=1.
- Window addressing, line 112: mem_re rises with mem_raddr=0 for 4 clocks, then 1,2,...,127, each held 4 clocks. Lines 113-115 repeat 0..127; line 116 yields 128..255.
- Memory model returns addr-derived data (rdata={11'h0,addr}); output h=64, v=112 shows that value 3 clocks after the counter; last pixel at v=367, h=572..575 shows addr 8191.
- Border: BORDER=24'h123456; pixels at h=10, v=10 and h=600, v=200 output 12/34/56; blanking h=700 outputs 0 with vga_de=0.
- Reset asserted mid-window (h=300, v=200): outputs return to reset values immediately; after release the raster restarts and the addresses match the first-frame sequence.
